// File: rtl/vga_pkg.sv
// Timing sets and sync-polarity constants shared by the VGA raster generator.
// The 640x480@60 set is the default; 800x600@60 is the alternative.
package vga_pkg;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock
    localparam int VGA640_H_ACTIVE     = 640;
    localparam int VGA640_H_SYNC_START = 656;
    localparam int VGA640_H_SYNC_END   = 752;
    localparam int VGA640_H_TOTAL      = 800;
    localparam bit VGA640_H_POL        = SYNC_ACTIVE_LOW;
    localparam int VGA640_V_ACTIVE     = 480;
    localparam int VGA640_V_SYNC_START = 490;
    localparam int VGA640_V_SYNC_END   = 492;
    localparam int VGA640_V_TOTAL      = 525;
    localparam bit VGA640_V_POL        = SYNC_ACTIVE_LOW;

    // 800x600 @ 60 Hz, 40 MHz pixel clock
    localparam int SVGA800_H_ACTIVE     = 800;
    localparam int SVGA800_H_SYNC_START = 840;
    localparam int SVGA800_H_SYNC_END   = 968;
    localparam int SVGA800_H_TOTAL      = 1056;
    localparam bit SVGA800_H_POL        = SYNC_ACTIVE_HIGH;
    localparam int SVGA800_V_ACTIVE     = 600;
    localparam int SVGA800_V_SYNC_START = 601;
    localparam int SVGA800_V_SYNC_END   = 605;
    localparam int SVGA800_V_TOTAL      = 628;
    localparam bit SVGA800_V_POL        = SYNC_ACTIVE_HIGH;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus combinational sync/visible decode of the current count.
// The wrap tick is combinational so the next axis can advance on the very same edge.
module vga_axis_counter #(
    parameter int CW         = 12,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int TOTAL      = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          sync_active,
    output logic          visible
);

    localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SS    = CW'(SYNC_START);
    localparam logic [CW-1:0] SE    = CW'(SYNC_END);
    localparam logic [CW-1:0] ACT   = CW'(ACTIVE);

    assign wrap        = advance && (count == LAST);
    assign sync_active = (count >= SS) && (count < SE);
    assign visible     = (count < ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (advance)
            count <= wrap ? '0 : count + CW'(1);
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: two chained axis counters feeding a registered
// output stage that loads on pixel-enable edges, plus per-clock start-of-line/frame strobes.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW           = 12,
    parameter int H_ACTIVE     = VGA640_H_ACTIVE,
    parameter int H_SYNC_START = VGA640_H_SYNC_START,
    parameter int H_SYNC_END   = VGA640_H_SYNC_END,
    parameter int H_TOTAL      = VGA640_H_TOTAL,
    parameter bit H_POL        = VGA640_H_POL,
    parameter int V_ACTIVE     = VGA640_V_ACTIVE,
    parameter int V_SYNC_START = VGA640_V_SYNC_START,
    parameter int V_SYNC_END   = VGA640_V_SYNC_END,
    parameter int V_TOTAL      = VGA640_V_TOTAL,
    parameter bit V_POL        = VGA640_V_POL
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pix_en,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_de,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_sol,
    output logic          o_sof
);

    if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL)) begin : g_bad_h
        $error("vga_timing_gen: illegal horizontal timing ordering");
    end
    if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL)) begin : g_bad_v
        $error("vga_timing_gen: illegal vertical timing ordering");
    end
    if (H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_w
        $error("vga_timing_gen: totals do not fit in CW bits");
    end

    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap_unused;
    logic          h_sync, v_sync, h_vis, v_vis;

    vga_axis_counter #(
        .CW(CW), .ACTIVE(H_ACTIVE), .SYNC_START(H_SYNC_START),
        .SYNC_END(H_SYNC_END), .TOTAL(H_TOTAL)
    ) u_h (
        .clk(i_clk), .rst_n(i_rst_n), .advance(i_pix_en), .count(h_cnt),
        .wrap(h_wrap), .sync_active(h_sync), .visible(h_vis)
    );

    // Vertical axis steps only on the horizontal line-end tick.
    vga_axis_counter #(
        .CW(CW), .ACTIVE(V_ACTIVE), .SYNC_START(V_SYNC_START),
        .SYNC_END(V_SYNC_END), .TOTAL(V_TOTAL)
    ) u_v (
        .clk(i_clk), .rst_n(i_rst_n), .advance(h_wrap), .count(v_cnt),
        .wrap(v_wrap_unused), .sync_active(v_sync), .visible(v_vis)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync <= ~H_POL;
            o_vsync <= ~V_POL;
            o_de    <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_sol   <= 1'b0;
            o_sof   <= 1'b0;
        end else begin
            // Strobes re-evaluate every clock so they stay one i_clk wide under a slow pix_en.
            o_sol <= i_pix_en && (h_cnt == '0);
            o_sof <= i_pix_en && (h_cnt == '0) && (v_cnt == '0);
            if (i_pix_en) begin
                o_hsync <= h_sync ? H_POL : ~H_POL;
                o_vsync <= v_sync ? V_POL : ~V_POL;
                o_de    <= h_vis && v_vis;
                o_x     <= h_cnt;
                o_y     <= v_cnt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: four generator instances (640x480, two small rasters, 800x600 active-high)
// share clock, reset and a randomized pixel enable; a linear-pixel-index model predicts outputs.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int NI = 4;
    localparam int HA  [NI] = '{VGA640_H_ACTIVE,     16, SVGA800_H_ACTIVE,     8};
    localparam int HSS [NI] = '{VGA640_H_SYNC_START, 18, SVGA800_H_SYNC_START, 9};
    localparam int HSE [NI] = '{VGA640_H_SYNC_END,   22, SVGA800_H_SYNC_END,   12};
    localparam int HT  [NI] = '{VGA640_H_TOTAL,      26, SVGA800_H_TOTAL,      12};
    localparam int VA  [NI] = '{VGA640_V_ACTIVE,     10, SVGA800_V_ACTIVE,     5};
    localparam int VSS [NI] = '{VGA640_V_SYNC_START, 12, SVGA800_V_SYNC_START, 6};
    localparam int VSE [NI] = '{VGA640_V_SYNC_END,   14, SVGA800_V_SYNC_END,   8};
    localparam int VT  [NI] = '{VGA640_V_TOTAL,      15, SVGA800_V_TOTAL,      9};
    localparam bit PH  [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam bit PV  [NI] = '{1'b0, 1'b0, 1'b1, 1'b1};

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] x;
        logic [11:0] y;
        logic        sol;
        logic        sof;
    } exp_t;
    typedef exp_t [NI-1:0] exp4_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b1;
    always #5 clk = ~clk;

    logic        hs [NI], vs [NI], de [NI], sol [NI], sof [NI];
    logic [11:0] ox [NI], oy [NI];
    exp4_t       act;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        vga_timing_gen #(
            .CW(12),
            .H_ACTIVE(HA[g]), .H_SYNC_START(HSS[g]), .H_SYNC_END(HSE[g]), .H_TOTAL(HT[g]), .H_POL(PH[g]),
            .V_ACTIVE(VA[g]), .V_SYNC_START(VSS[g]), .V_SYNC_END(VSE[g]), .V_TOTAL(VT[g]), .V_POL(PV[g])
        ) u_dut (
            .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en),
            .o_hsync(hs[g]), .o_vsync(vs[g]), .o_de(de[g]),
            .o_x(ox[g]), .o_y(oy[g]), .o_sol(sol[g]), .o_sof(sof[g])
        );
        assign act[g] = {hs[g], vs[g], de[g], ox[g], oy[g], sol[g], sof[g]};
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    exp4_t sb [$];

    function automatic exp_t rst_val(int k);
        exp_t e;
        e     = '0;
        e.hs  = ~PH[k];
        e.vs  = ~PV[k];
        return e;
    endfunction

    // Outputs for linear pixel index p within the frame of instance k.
    function automatic exp_t decode(int k, int p);
        exp_t e;
        int x, y;
        x     = p % HT[k];
        y     = p / HT[k];
        e.hs  = (x >= HSS[k] && x < HSE[k]) ? PH[k] : ~PH[k];
        e.vs  = (y >= VSS[k] && y < VSE[k]) ? PV[k] : ~PV[k];
        e.de  = (x < HA[k]) && (y < VA[k]);
        e.x   = 12'(x);
        e.y   = 12'(y);
        e.sol = (x == 0);
        e.sof = (p == 0);
        return e;
    endfunction

    function automatic void check(string name, exp_t a, exp_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got hs=%b vs=%b de=%b x=%0d y=%0d sol=%b sof=%b, want hs=%b vs=%b de=%b x=%0d y=%0d sol=%b sof=%b",
                     name, a.hs, a.vs, a.de, a.x, a.y, a.sol, a.sof,
                     e.hs, e.vs, e.de, e.x, e.y, e.sol, e.sof);
        end
    endfunction

    // Reference model: push the outputs expected after each rising edge.
    initial begin
        exp4_t cur;
        int    pix [NI];
        for (int k = 0; k < NI; k++) begin
            cur[k] = rst_val(k);
            pix[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (!rst_n) begin
                    cur[k] = rst_val(k);
                    pix[k] = 0;
                end else if (pix_en) begin
                    cur[k] = decode(k, pix[k]);
                    pix[k] = (pix[k] + 1) % (HT[k] * VT[k]);
                end else begin
                    cur[k].sol = 1'b0;
                    cur[k].sof = 1'b0;
                end
            end
            sb.push_back(cur);
        end
    end

    // Monitor: compare DUT outputs mid-cycle against the oldest prediction.
    initial begin
        exp4_t e;
        int    cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < NI; k++)
                    check($sformatf("inst%0d_cyc%0d", k, cyc), act[k], e[k]);
            end
        end
    end

    task automatic run(int n, int mode);
        repeat (n) begin
            @(negedge clk);
            #1;
            case (mode)
                0:       pix_en = 1'b1;
                1:       pix_en = ~pix_en;
                default: pix_en = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    initial begin
        bit found;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        run(3000, 0);
        pix_en = 1'b0;
        run(3000, 1);
        run(2500, 2);

        // Mid-line reset on the 640x480 instance at x = 300.
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (ox[0] == 12'd300) found = 1'b1;
            else begin
                #1 pix_en = ($urandom_range(0, 1) != 0);
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_x300: got x=%0d, want 300 within 3000 cycles", ox[0]);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++)
            check($sformatf("async_rst_inst%0d", k), act[k], rst_val(k));
        run(3, 2);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pix_en = 1'b1;
        run(2000, 2);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
